pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer. It is the next-generation pipeline register for the pipelined core. It replaces the fixed 32-bit enable-only stage register with:
- configurable width and reset value
- full-throughput backpressure
- synchronous flush for branch/hazard squashing

It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_skid_stage.sv | 139 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Parametrised pipeline stage with valid/ready handshake on both
//            sides and a two-entry (main + skid) buffer. Full throughput,
//            registered ready/valid, synchronous flush.
// Options  : PIPE_STALL_CNT_EN adds a saturating backpressure cycle counter
//            on the stall_cnt port (width CNT_WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
`ifdef PIPE_STALL_CNT_EN
  ,parameter int             CNT_WIDTH   = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic             accept;
  logic             take;

  // Handshake flags are decoded from the state register only, so neither
  // ready nor valid has a combinational path from the opposite side.
  assign out_valid = (state != S_EMPTY);
  assign in_ready  = (state != S_FULL);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and data-register load decode; flush overrides everything
  // and suppresses all loads so OUT keeps its last value.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = S_BUSY;
          end
        end
        S_BUSY: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = S_FULL;
          end else if (take) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a take can move the state.
          if (take) begin
            load_main_skid = 1'b1;
            state_nxt      = S_BUSY;
          end
        end
        default: begin
          state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Main (output) and skid payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of cycles with valid data held back by downstream;
  // only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Self-checking bench for pipe_skid_stage. A queue-based model of
//            the stage is compared against the DUT every cycle; directed
//            sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'hDEADBEEF;
`ifdef PIPE_STALL_CNT_EN
  localparam int          CW    = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0]    stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_skid_stage #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV)
`ifdef PIPE_STALL_CNT_EN
    ,.CNT_WIDTH  (CW)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a 2-deep FIFO ----------------
  logic [31:0] mq[$];
  logic [31:0] m_last;
  int          m_cnt;
  bit          m_take, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = RV;
      m_cnt  = 0;
    end else begin
      m_take = (mq.size() > 0) && out_ready;
      m_acc  = in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !out_ready && (m_cnt < 15)) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_take) void'(mq.pop_front());
        if (m_acc)  mq.push_back(in_data);
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Compare process: outputs only change at posedge/reset, so negedge is safe.
  always @(negedge clk) begin
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("m_in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
    chk("m_out_data",  out_data, m_last);
`ifdef PIPE_STALL_CNT_EN
    chk("m_stall_cnt", {28'd0, stall_cnt}, m_cnt);
`endif
  end

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom());
      out_ready = 1'($urandom());
      flush     = 1'($urandom());
      in_data   = $urandom();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_data",  out_data, 32'hDEADBEEF);
    end
    idle();
    rst_n = 1'b1;

    // Streaming 1..4 at full rate.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("stream_out", out_data, i);
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_ready", {31'd0, in_ready}, 32'd1);
      end
      if (i < 4) begin
        in_valid = 1'b1;
        in_data  = i + 1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Skid: BUSY with 5, stall, accept 6.
    in_valid = 1'b1; in_data = 5; out_ready = 1'b0;
    @(negedge clk);
    chk("skid_busy_out", out_data, 5);
    chk("skid_busy_rdy", {31'd0, in_ready}, 32'd1);
    in_data = 6;
    @(negedge clk);
    chk("skid_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("skid_hold_out", out_data, 5);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("skid_out6", out_data, 6);
    chk("skid_rdy_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("skid_empty", {31'd0, out_valid}, 32'd0);

    // Flush in FULL with 7,8; 9 offered during flush.
    in_valid = 1'b1; in_data = 7; out_ready = 1'b0;
    @(negedge clk);
    in_data = 8;
    @(negedge clk);
    flush = 1'b1; in_data = 9;
    @(negedge clk);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_kept", out_data, 7);
    idle();
    @(negedge clk);
    chk("flush_no9", {31'd0, out_valid}, 32'd0);

    // Flush in BUSY: 10 held, 9 accepted in the flush cycle is discarded.
    in_valid = 1'b1; in_data = 10; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_data = 9;
    @(negedge clk);
    chk("flush2_valid", {31'd0, out_valid}, 32'd0);
    chk("flush2_out", out_data, 10);
    flush = 1'b0; in_data = 11; out_ready = 1'b1;
    @(negedge clk);
    chk("flush2_resume", out_data, 11);
    idle();
    @(negedge clk);

    // Async reset while FULL.
    in_valid = 1'b1; in_data = 12; out_ready = 1'b0;
    @(negedge clk);
    in_data = 13;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out", out_data, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 14; out_ready = 1'b1;
    @(negedge clk);
    chk("arst_resume", out_data, 14);
    idle();
    @(negedge clk);

`ifdef PIPE_STALL_CNT_EN
    // Saturating stall counter.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 20; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("cnt_sat", {28'd0, stall_cnt}, 15);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("cnt_flush_kept", {28'd0, stall_cnt}, 15);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", {28'd0, stall_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
